write_emib: RTL and testbench

Writes a block of words supplied by the MM module into the EMIB RAM. The MM module streams the words in; `write_emib` writes them to consecutive RAM addresses starting at `i_base_addr + i_offset_addr`. A 4-entry internal buffer decouples the MM-side handshake from RAM-side wait states. The block ends each command with a one-cycle done or error pulse.

---
 rtl/write_emib.sv | 186 ++++++++++++++++++
 tb/tb_write_emib.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/write_emib.sv
// Streams a block of MM words into consecutive EMIB RAM addresses through a 4-entry buffer.
// Optional running sum of committed words: define WRITE_EMIB_SUM_EN.
module write_emib #(
  parameter int unsigned RAM_WIDTH = 16,
  parameter int unsigned ADDR_SZ   = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_wr_en,
  input  logic                 i_error,
  input  logic [ADDR_SZ-1:0]   i_mm_data_len,
  input  logic [ADDR_SZ-1:0]   i_base_addr,
  input  logic [ADDR_SZ-1:0]   i_offset_addr,
  input  logic [RAM_WIDTH-1:0] i_mm_data,
  input  logic                 i_mm_vld,
  output logic                 o_mm_rdy,
  output logic                 o_emib_wr_en,
  output logic [ADDR_SZ-1:0]   o_emib_addr,
  output logic [RAM_WIDTH-1:0] o_emib_data,
  input  logic                 i_emib_wait,
  output logic                 o_busy,
  output logic                 o_write_done,
  output logic                 o_write_error,
  output logic [ADDR_SZ-1:0]   o_wr_cnt
`ifdef WRITE_EMIB_SUM_EN
  ,
  output logic [RAM_WIDTH-1:0] o_wr_sum
`endif
);

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned PTR_W      = 2;
  localparam int unsigned CNT_W      = 3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_JUDGE = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  logic [2:0]           state_q, state_d;
  logic [ADDR_SZ-1:0]   len_q, len_d;
  logic [ADDR_SZ-1:0]   start_q, start_d;
  logic [ADDR_SZ-1:0]   acc_q, acc_d;
  logic [ADDR_SZ-1:0]   wr_cnt_d;
  logic [CNT_W-1:0]     fcnt_q, fcnt_d;
  logic [PTR_W-1:0]     rd_q, rd_d, wr_q, wr_d;
  logic                 rdy_d, wr_en_d, busy_d, done_d, err_d;
  logic [ADDR_SZ-1:0]   addr_d;
  logic [RAM_WIDTH-1:0] data_d;
  logic                 accept, commit, push, pop, bypass;
  logic [RAM_WIDTH-1:0] mem [FIFO_DEPTH];

  assign accept = o_mm_rdy && i_mm_vld;
  assign commit = o_emib_wr_en && !i_emib_wait;

  // Next-state and registered-output logic; an empty buffer forwards the accepted word directly.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    start_d  = start_q;
    acc_d    = acc_q;
    wr_cnt_d = o_wr_cnt;
    fcnt_d   = fcnt_q;
    rd_d     = rd_q;
    wr_d     = wr_q;
    wr_en_d  = o_emib_wr_en;
    addr_d   = o_emib_addr;
    data_d   = o_emib_data;
    push     = 1'b0;
    pop      = 1'b0;
    bypass   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (i_wr_en) begin
          state_d  = S_JUDGE;
          len_d    = i_mm_data_len;
          start_d  = ADDR_SZ'(i_base_addr + i_offset_addr);
          acc_d    = '0;
          wr_cnt_d = '0;
          fcnt_d   = '0;
          rd_d     = '0;
          wr_d     = '0;
        end
      end
      S_JUDGE: begin
        if (i_error)            state_d = S_ERR;
        else if (len_q == '0)   state_d = S_DONE;
        else                    state_d = S_WRITE;
      end
      S_WRITE: begin
        if (accept) acc_d = ADDR_SZ'(acc_q + 1'b1);
        if (commit) wr_cnt_d = ADDR_SZ'(o_wr_cnt + 1'b1);
        if (!o_emib_wr_en || !i_emib_wait) begin
          if (fcnt_q != '0) begin
            pop     = 1'b1;
            data_d  = mem[rd_q];
            wr_en_d = 1'b1;
            addr_d  = ADDR_SZ'(start_q + wr_cnt_d);
          end else if (accept) begin
            bypass  = 1'b1;
            data_d  = i_mm_data;
            wr_en_d = 1'b1;
            addr_d  = ADDR_SZ'(start_q + wr_cnt_d);
          end else begin
            wr_en_d = 1'b0;
          end
        end
        push = accept && !bypass;
        if (push) wr_d = PTR_W'(wr_q + 1'b1);
        if (pop)  rd_d = PTR_W'(rd_q + 1'b1);
        fcnt_d = CNT_W'(fcnt_q + CNT_W'(push) - CNT_W'(pop));
        if (commit && (o_wr_cnt == ADDR_SZ'(len_q - 1'b1))) begin
          state_d = S_DONE;
          wr_en_d = 1'b0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    err_d  = (state_d == S_ERR);
    rdy_d  = (state_d == S_WRITE) && (fcnt_d < CNT_W'(FIFO_DEPTH)) && (acc_d < len_d);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= S_IDLE;
      len_q         <= '0;
      start_q       <= '0;
      acc_q         <= '0;
      fcnt_q        <= '0;
      rd_q          <= '0;
      wr_q          <= '0;
      o_mm_rdy      <= 1'b0;
      o_emib_wr_en  <= 1'b0;
      o_emib_addr   <= '0;
      o_emib_data   <= '0;
      o_busy        <= 1'b0;
      o_write_done  <= 1'b0;
      o_write_error <= 1'b0;
      o_wr_cnt      <= '0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      start_q       <= start_d;
      acc_q         <= acc_d;
      fcnt_q        <= fcnt_d;
      rd_q          <= rd_d;
      wr_q          <= wr_d;
      o_mm_rdy      <= rdy_d;
      o_emib_wr_en  <= wr_en_d;
      o_emib_addr   <= addr_d;
      o_emib_data   <= data_d;
      o_busy        <= busy_d;
      o_write_done  <= done_d;
      o_write_error <= err_d;
      o_wr_cnt      <= wr_cnt_d;
    end
  end

  // Buffer storage; contents are only meaningful below fcnt_q, so no reset.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_q] <= i_mm_data;
  end

`ifdef WRITE_EMIB_SUM_EN
  logic [RAM_WIDTH-1:0] sum_d;

  always_comb begin
    sum_d = o_wr_sum;
    if (state_q == S_IDLE && i_wr_en) sum_d = '0;
    else if (commit)                  sum_d = RAM_WIDTH'(o_wr_sum + o_emib_data);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) o_wr_sum <= '0;
    else          o_wr_sum <= sum_d;
  end
`endif

endmodule

// File: tb/tb_write_emib.sv
// Directed self-checking bench for write_emib: basic, error, stall, wrap, zero length, reset abort.
module tb_write_emib;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_wr_en, i_error, i_mm_vld, i_emib_wait;
  logic [15:0] i_mm_data_len, i_base_addr, i_offset_addr, i_mm_data;
  logic        o_mm_rdy, o_emib_wr_en, o_busy, o_write_done, o_write_error;
  logic [15:0] o_emib_addr, o_emib_data, o_wr_cnt;
`ifdef WRITE_EMIB_SUM_EN
  logic [15:0] o_wr_sum;
  logic [15:0] sum_cap;
`endif

  int errors = 0;
  int checks = 0;
  logic [15:0] wdata [16];

  write_emib #(.RAM_WIDTH(16), .ADDR_SZ(16)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_wr_en(i_wr_en), .i_error(i_error),
    .i_mm_data_len(i_mm_data_len), .i_base_addr(i_base_addr), .i_offset_addr(i_offset_addr),
    .i_mm_data(i_mm_data), .i_mm_vld(i_mm_vld), .o_mm_rdy(o_mm_rdy),
    .o_emib_wr_en(o_emib_wr_en), .o_emib_addr(o_emib_addr), .o_emib_data(o_emib_data),
    .i_emib_wait(i_emib_wait), .o_busy(o_busy), .o_write_done(o_write_done),
    .o_write_error(o_write_error), .o_wr_cnt(o_wr_cnt)
`ifdef WRITE_EMIB_SUM_EN
    , .o_wr_sum(o_wr_sum)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({o_mm_rdy, o_emib_wr_en, o_emib_addr, o_emib_data, o_busy,
                o_write_done, o_write_error, o_wr_cnt});
  endfunction

  // Runs one command; cycle 0 is the i_wr_en cycle. Checks each commit against start+index and wdata.
  task automatic run_cmd(input logic [15:0] base, input logic [15:0] off, input logic [15:0] len,
                         input logic err, input int stall_len, input int abort_after,
                         output int done_cyc, output int err_cyc, output int n_wr,
                         output int n_strobe, output int acc_stall_end, output logic saw_bp);
    int acc, first_wr;
    logic held;
    logic [15:0] start, hold_a, hold_d, exp_a;
    start = 16'(base + off);
    acc = 0; n_wr = 0; n_strobe = 0; done_cyc = -1; err_cyc = -1;
    first_wr = -1; held = 1'b0; acc_stall_end = -1; saw_bp = 1'b0;
    hold_a = '0; hold_d = '0;
    i_base_addr = base; i_offset_addr = off; i_mm_data_len = len; i_error = err;
    i_wr_en = 1'b1;
    for (int cyc = 0; cyc < 200; cyc++) begin
      i_emib_wait = (first_wr >= 0) && (cyc > first_wr) && (cyc <= first_wr + stall_len);
      i_mm_vld    = (cyc >= 1) && (acc < int'(len));
      i_mm_data   = (acc < 16) ? wdata[acc] : 16'h0;
      if (o_emib_wr_en) begin
        n_strobe++;
        if (first_wr < 0) first_wr = cyc;
        if (held) begin
          chk("hold_addr", 64'(o_emib_addr), 64'(hold_a));
          chk("hold_data", 64'(o_emib_data), 64'(hold_d));
        end
        if (i_emib_wait) begin
          held = 1'b1; hold_a = o_emib_addr; hold_d = o_emib_data;
        end else begin
          held = 1'b0;
          exp_a = 16'(start + 16'(n_wr));
          chk("wr_addr", 64'(o_emib_addr), 64'(exp_a));
          chk("wr_data", 64'(o_emib_data), 64'(wdata[n_wr]));
          n_wr++;
        end
      end else begin
        held = 1'b0;
      end
      chk("rdy_limit", 64'(o_mm_rdy && (acc >= int'(len))), 64'(0));
      if (first_wr >= 0 && !o_mm_rdy && acc < int'(len) && o_busy) saw_bp = 1'b1;
      if (o_mm_rdy && i_mm_vld) acc++;
      if (first_wr >= 0 && cyc == first_wr + stall_len) acc_stall_end = acc;
      if (cyc >= 1) chk("busy", 64'(o_busy), 64'(1));
      if (o_write_done && done_cyc < 0) done_cyc = cyc;
      if (o_write_error && err_cyc < 0) err_cyc = cyc;
`ifdef WRITE_EMIB_SUM_EN
      if (o_write_done) sum_cap = o_wr_sum;
`endif
      if (abort_after > 0 && n_wr == abort_after) return;
      if (done_cyc >= 0 || err_cyc >= 0) begin
        i_mm_vld = 1'b0; i_emib_wait = 1'b0;
        tick();
        chk("pulse_len_done", 64'(o_write_done), 64'(0));
        chk("pulse_len_err", 64'(o_write_error), 64'(0));
        chk("busy_after", 64'(o_busy), 64'(0));
        return;
      end
      tick();
      i_wr_en = 1'b0;
    end
    chk("timeout", 64'(done_cyc >= 0 || err_cyc >= 0), 64'(1));
  endtask

  initial begin
    int dc, ec, nw, ns, ase;
    logic bp;
    i_rst_n = 1'b0; i_wr_en = 1'b0; i_error = 1'b0; i_mm_vld = 1'b0; i_emib_wait = 1'b0;
    i_mm_data_len = '0; i_base_addr = '0; i_offset_addr = '0; i_mm_data = '0;
    for (int i = 0; i < 16; i++) wdata[i] = 16'(16'h1111 * (i + 1));
    tick(); tick();
    chk("reset_outs", all_outs(), 64'(0));
    i_rst_n = 1'b1;
    tick();
    chk("idle_outs", all_outs(), 64'(0));

    // Basic write: 0x0100+0x0010, 4 words
    run_cmd(16'h0100, 16'h0010, 16'd4, 1'b0, 0, 0, dc, ec, nw, ns, ase, bp);
    chk("basic_done_cyc", 64'(dc), 64'(7));
    chk("basic_nwr", 64'(nw), 64'(4));
    chk("basic_wr_cnt", 64'(o_wr_cnt), 64'(4));
    chk("basic_no_err", 64'(ec), 64'(-1));

    // Error path
    run_cmd(16'h0200, 16'h0000, 16'd4, 1'b1, 0, 0, dc, ec, nw, ns, ase, bp);
    i_error = 1'b0;
    chk("err_cyc", 64'(ec), 64'(2));
    chk("err_strobes", 64'(ns), 64'(0));
    chk("err_wr_cnt", 64'(o_wr_cnt), 64'(0));

    // Stall and backpressure: 6-cycle wait after first write, len 8
    run_cmd(16'h0300, 16'h0004, 16'd8, 1'b0, 6, 0, dc, ec, nw, ns, ase, bp);
    chk("stall_nwr", 64'(nw), 64'(8));
    chk("stall_bp", 64'(bp), 64'(1));
    chk("stall_acc", 64'(ase), 64'(6));
    chk("stall_wr_cnt", 64'(o_wr_cnt), 64'(8));

    // Address wrap
    run_cmd(16'hFFFE, 16'h0000, 16'd4, 1'b0, 0, 0, dc, ec, nw, ns, ase, bp);
    chk("wrap_nwr", 64'(nw), 64'(4));
    chk("wrap_done_cyc", 64'(dc), 64'(7));
    chk("wrap_last_addr", 64'(o_emib_addr), 64'(16'h0001));

    // Zero length
    run_cmd(16'h0400, 16'h0000, 16'd0, 1'b0, 0, 0, dc, ec, nw, ns, ase, bp);
    chk("zero_done_cyc", 64'(dc), 64'(2));
    chk("zero_strobes", 64'(ns), 64'(0));

    // Reset abort after 3 writes
    run_cmd(16'h0500, 16'h0000, 16'd6, 1'b0, 0, 3, dc, ec, nw, ns, ase, bp);
    chk("abort_nwr", 64'(nw), 64'(3));
    i_rst_n = 1'b0; i_mm_vld = 1'b0; i_wr_en = 1'b0;
    #1;
    chk("abort_outs", all_outs(), 64'(0));
    tick();
    i_rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_no_pulse", 64'({o_write_done, o_write_error, o_busy, o_emib_wr_en}), 64'(0));
    end

    // Fresh command after reset
    wdata[0] = 16'hFFFF; wdata[1] = 16'h0002; wdata[2] = 16'h0010;
    run_cmd(16'h0600, 16'h0001, 16'd3, 1'b0, 0, 0, dc, ec, nw, ns, ase, bp);
    chk("post_reset_done_cyc", 64'(dc), 64'(6));
    chk("post_reset_nwr", 64'(nw), 64'(3));
`ifdef WRITE_EMIB_SUM_EN
    chk("sum_at_done", 64'(sum_cap), 64'(16'h0011));
    chk("sum_stable", 64'(o_wr_sum), 64'(16'h0011));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
